// File: rtl/parking_slot_arbiter.sv
// parking_slot_arbiter: owns the parking occupancy vector and serialises
// entry and exit gate requests against it. Entries take the lowest free slot,
// exits clear their one-hot slot, and every successful grant opens the gate
// for GATE_CYCLES cycles.
// Optional macro PARKING_RR_ARB_EN: round-robin between simultaneous entry and
// exit requests. Without it, exit always wins a conflict.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// S_IDLE    | sample requests, serve one per edge
// S_GATE    | gate actuator open, down-counter running
// S_RELEASE | wait for the served requester to drop its request
module parking_slot_arbiter #(
    parameter int N_SLOTS     = 8,
    parameter int GATE_CYCLES = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         entry_req,
    input  logic                         exit_req,
    input  logic [N_SLOTS-1:0]           exit_slot,
    output logic                         entry_ack,
    output logic [N_SLOTS-1:0]           entry_slot,
    output logic                         entry_reject,
    output logic                         exit_ack,
    output logic                         exit_err,
    output logic                         gate_open,
    output logic [N_SLOTS-1:0]           capacity,
    output logic [$clog2(N_SLOTS+1)-1:0] occupied_count,
    output logic                         full,
    output logic                         empty
);

    localparam int CW = $clog2(N_SLOTS + 1);
    localparam int GW = $clog2(GATE_CYCLES + 1);

    typedef enum logic [1:0] {S_IDLE, S_GATE, S_RELEASE} state_t;

    state_t               r_state, w_state_nxt;
    logic [GW-1:0]        r_gate_cnt, w_gate_cnt_nxt;
    logic [N_SLOTS-1:0]   r_capacity, w_capacity_nxt;
    logic [CW-1:0]        r_count, w_count_nxt;
    logic [N_SLOTS-1:0]   r_entry_slot, w_entry_slot_nxt;
    logic                 r_full, r_empty;
    logic                 r_entry_ack, r_entry_reject, r_exit_ack, r_exit_err;
    logic                 w_entry_ack_nxt, w_entry_reject_nxt, w_exit_ack_nxt, w_exit_err_nxt;
    logic                 r_served_exit, w_served_exit_nxt;
    logic                 w_serve_entry, w_serve_exit;
    logic [N_SLOTS-1:0]   w_free, w_lowest;
    logic                 w_exit_valid;

    assign w_free       = ~r_capacity;
    assign w_lowest     = w_free & (~w_free + N_SLOTS'(1));
    assign w_exit_valid = (exit_slot != '0)
                       && ((exit_slot & (exit_slot - N_SLOTS'(1))) == '0)
                       && ((exit_slot & r_capacity) != '0);

`ifdef PARKING_RR_ARB_EN
    logic r_rr_entry;

    // Conflict resolution: the pointer names the requester that wins a tie
    always_comb begin
        w_serve_entry = entry_req && (!exit_req || r_rr_entry);
        w_serve_exit  = exit_req && !w_serve_entry;
    end

    // Pointer moves to the requester that was not just served
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rr_entry <= 1'b1;
        end else if (r_state == S_IDLE && (w_serve_entry || w_serve_exit)) begin
            r_rr_entry <= w_serve_exit;
        end
    end
`else
    // Fixed priority: freeing a slot first maximises later grants
    always_comb begin
        w_serve_exit  = exit_req;
        w_serve_entry = entry_req && !exit_req;
    end
`endif

    // Next-state, next-occupancy and pulse decode
    always_comb begin
        w_state_nxt        = r_state;
        w_gate_cnt_nxt     = r_gate_cnt;
        w_capacity_nxt     = r_capacity;
        w_count_nxt        = r_count;
        w_entry_slot_nxt   = r_entry_slot;
        w_served_exit_nxt  = r_served_exit;
        w_entry_ack_nxt    = 1'b0;
        w_entry_reject_nxt = 1'b0;
        w_exit_ack_nxt     = 1'b0;
        w_exit_err_nxt     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_serve_entry) begin
                    w_served_exit_nxt = 1'b0;
                    if (r_full) begin
                        w_entry_reject_nxt = 1'b1;
                        w_state_nxt        = S_RELEASE;
                    end else begin
                        w_capacity_nxt   = r_capacity | w_lowest;
                        w_entry_slot_nxt = w_lowest;
                        w_entry_ack_nxt  = 1'b1;
                        w_count_nxt      = r_count + CW'(1);
                        w_gate_cnt_nxt   = GW'(GATE_CYCLES - 1);
                        w_state_nxt      = S_GATE;
                    end
                end else if (w_serve_exit) begin
                    w_served_exit_nxt = 1'b1;
                    if (w_exit_valid) begin
                        w_capacity_nxt = r_capacity ^ exit_slot;
                        w_exit_ack_nxt = 1'b1;
                        w_count_nxt    = r_count - CW'(1);
                        w_gate_cnt_nxt = GW'(GATE_CYCLES - 1);
                        w_state_nxt    = S_GATE;
                    end else begin
                        w_exit_err_nxt = 1'b1;
                        w_state_nxt    = S_RELEASE;
                    end
                end
            end
            S_GATE: begin
                if (r_gate_cnt == '0) begin
                    w_state_nxt = S_RELEASE;
                end else begin
                    w_gate_cnt_nxt = r_gate_cnt - GW'(1);
                end
            end
            S_RELEASE: begin
                if (r_served_exit ? !exit_req : !entry_req) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // State, occupancy and registered status/pulse outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= S_IDLE;
            r_gate_cnt     <= '0;
            r_capacity     <= '0;
            r_count        <= '0;
            r_full         <= 1'b0;
            r_empty        <= 1'b1;
            r_entry_slot   <= '0;
            r_served_exit  <= 1'b0;
            r_entry_ack    <= 1'b0;
            r_entry_reject <= 1'b0;
            r_exit_ack     <= 1'b0;
            r_exit_err     <= 1'b0;
        end else begin
            r_state        <= w_state_nxt;
            r_gate_cnt     <= w_gate_cnt_nxt;
            r_capacity     <= w_capacity_nxt;
            r_count        <= w_count_nxt;
            r_full         <= &w_capacity_nxt;
            r_empty        <= ~|w_capacity_nxt;
            r_entry_slot   <= w_entry_slot_nxt;
            r_served_exit  <= w_served_exit_nxt;
            r_entry_ack    <= w_entry_ack_nxt;
            r_entry_reject <= w_entry_reject_nxt;
            r_exit_ack     <= w_exit_ack_nxt;
            r_exit_err     <= w_exit_err_nxt;
        end
    end

    assign gate_open      = (r_state == S_GATE);
    assign capacity       = r_capacity;
    assign occupied_count = r_count;
    assign full           = r_full;
    assign empty          = r_empty;
    assign entry_slot     = r_entry_slot;
    assign entry_ack      = r_entry_ack;
    assign entry_reject   = r_entry_reject;
    assign exit_ack       = r_exit_ack;
    assign exit_err       = r_exit_err;

endmodule

// File: tb/tb_parking_slot_arbiter.sv
// Directed bench for parking_slot_arbiter: a table of single-request
// transactions with hand-computed results, plus hand-written sequences for
// simultaneous requests and reset during an open gate.
module tb_parking_slot_arbiter;

    localparam int N  = 8;
    localparam int GC = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       entry_req, exit_req;
    logic [7:0] exit_slot;
    logic       entry_ack, entry_reject, exit_ack, exit_err, gate_open;
    logic [7:0] entry_slot, capacity;
    logic [3:0] occupied_count;
    logic       full, empty;

    int n_vec = 0;
    int n_err = 0;

    parking_slot_arbiter #(.N_SLOTS(N), .GATE_CYCLES(GC)) dut (
        .clk(clk), .rst_n(rst_n),
        .entry_req(entry_req), .exit_req(exit_req), .exit_slot(exit_slot),
        .entry_ack(entry_ack), .entry_slot(entry_slot), .entry_reject(entry_reject),
        .exit_ack(exit_ack), .exit_err(exit_err), .gate_open(gate_open),
        .capacity(capacity), .occupied_count(occupied_count),
        .full(full), .empty(empty)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       e;
        logic       x;
        logic [7:0] slot;
        logic       ack;
        logic       rej;
        logic       xack;
        logic       err;
        logic [7:0] eslot;
        logic [7:0] cap;
        logic [3:0] cnt;
        int         gate;
    } vec_t;

    vec_t tbl[28];

    function automatic vec_t ent(logic [7:0] es, logic [7:0] c, logic [3:0] n);
        vec_t v = '{e:1'b1, x:1'b0, slot:8'h00, ack:1'b1, rej:1'b0, xack:1'b0, err:1'b0,
                    eslot:es, cap:c, cnt:n, gate:GC};
        return v;
    endfunction

    function automatic vec_t rej(logic [7:0] es, logic [7:0] c, logic [3:0] n);
        vec_t v = '{e:1'b1, x:1'b0, slot:8'h00, ack:1'b0, rej:1'b1, xack:1'b0, err:1'b0,
                    eslot:es, cap:c, cnt:n, gate:0};
        return v;
    endfunction

    function automatic vec_t xok(logic [7:0] s, logic [7:0] es, logic [7:0] c, logic [3:0] n);
        vec_t v = '{e:1'b0, x:1'b1, slot:s, ack:1'b0, rej:1'b0, xack:1'b1, err:1'b0,
                    eslot:es, cap:c, cnt:n, gate:GC};
        return v;
    endfunction

    function automatic vec_t xer(logic [7:0] s, logic [7:0] es, logic [7:0] c, logic [3:0] n);
        vec_t v = '{e:1'b0, x:1'b1, slot:s, ack:1'b0, rej:1'b0, xack:1'b0, err:1'b1,
                    eslot:es, cap:c, cnt:n, gate:0};
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    // results captured by run_txn
    logic       c_ack, c_rej, c_xack, c_err, c_full, c_empty, c_extra;
    logic [7:0] c_eslot, c_cap;
    logic [3:0] c_cnt;
    int         c_gate;

    task automatic run_txn(input logic e, input logic x, input logic [7:0] s);
        @(negedge clk);
        entry_req = e; exit_req = x; exit_slot = s;
        @(posedge clk); #1;
        c_ack = entry_ack; c_rej = entry_reject; c_xack = exit_ack; c_err = exit_err;
        c_eslot = entry_slot; c_cap = capacity; c_cnt = occupied_count;
        c_full = full; c_empty = empty;
        c_gate = gate_open ? 1 : 0;
        c_extra = 1'b0;
        @(negedge clk);
        entry_req = 1'b0; exit_req = 1'b0;
        repeat (GC + 2) begin
            @(posedge clk); #1;
            if (gate_open) c_gate++;
            c_extra = c_extra | entry_ack | entry_reject | exit_ack | exit_err;
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, " capacity"}, capacity, 8'h00);
        chk({tag, " count"}, occupied_count, 4'd0);
        chk({tag, " empty"}, empty, 1'b1);
        chk({tag, " full"}, full, 1'b0);
        chk({tag, " entry_slot"}, entry_slot, 8'h00);
        chk({tag, " gate_open"}, gate_open, 1'b0);
        chk({tag, " pulses"}, {entry_ack, entry_reject, exit_ack, exit_err}, 4'b0000);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int  wcyc;
        logic got;

        tbl[0]  = ent(8'h01, 8'h01, 4'd1);
        tbl[1]  = ent(8'h02, 8'h03, 4'd2);
        tbl[2]  = ent(8'h04, 8'h07, 4'd3);
        tbl[3]  = ent(8'h08, 8'h0F, 4'd4);
        tbl[4]  = ent(8'h10, 8'h1F, 4'd5);
        tbl[5]  = ent(8'h20, 8'h3F, 4'd6);
        tbl[6]  = ent(8'h40, 8'h7F, 4'd7);
        tbl[7]  = xok(8'h01, 8'h40, 8'h7E, 4'd6);
        tbl[8]  = xok(8'h02, 8'h40, 8'h7C, 4'd5);
        tbl[9]  = xok(8'h10, 8'h40, 8'h6C, 4'd4);
        tbl[10] = ent(8'h01, 8'h6D, 4'd5);
        tbl[11] = ent(8'h02, 8'h6F, 4'd6);
        tbl[12] = ent(8'h10, 8'h7F, 4'd7);
        tbl[13] = ent(8'h80, 8'hFF, 4'd8);
        tbl[14] = xok(8'h01, 8'h80, 8'hFE, 4'd7);
        tbl[15] = xok(8'h02, 8'h80, 8'hFC, 4'd6);
        tbl[16] = xok(8'h10, 8'h80, 8'hEC, 4'd5);
        tbl[17] = xok(8'h80, 8'h80, 8'h6C, 4'd4);
        tbl[18] = ent(8'h01, 8'h6D, 4'd5);
        tbl[19] = ent(8'h02, 8'h6F, 4'd6);
        tbl[20] = ent(8'h10, 8'h7F, 4'd7);
        tbl[21] = ent(8'h80, 8'hFF, 4'd8);
        tbl[22] = rej(8'h80, 8'hFF, 4'd8);
        tbl[23] = xok(8'h10, 8'h80, 8'hEF, 4'd7);
        tbl[24] = xer(8'h10, 8'h80, 8'hEF, 4'd7);
        tbl[25] = xer(8'h06, 8'h80, 8'hEF, 4'd7);
        tbl[26] = xer(8'h00, 8'h80, 8'hEF, 4'd7);
        tbl[27] = ent(8'h10, 8'hFF, 4'd8);

        rst_n = 1'b0; entry_req = 1'b0; exit_req = 1'b0; exit_slot = 8'h00;
        #12;
        chk_reset_vals("reset");
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 28; i++) begin
            run_txn(tbl[i].e, tbl[i].x, tbl[i].slot);
            chk($sformatf("row%0d entry_ack", i), c_ack, tbl[i].ack);
            chk($sformatf("row%0d entry_reject", i), c_rej, tbl[i].rej);
            chk($sformatf("row%0d exit_ack", i), c_xack, tbl[i].xack);
            chk($sformatf("row%0d exit_err", i), c_err, tbl[i].err);
            chk($sformatf("row%0d entry_slot", i), c_eslot, tbl[i].eslot);
            chk($sformatf("row%0d capacity", i), c_cap, tbl[i].cap);
            chk($sformatf("row%0d count", i), c_cnt, tbl[i].cnt);
            chk($sformatf("row%0d full", i), c_full, tbl[i].cap == 8'hFF);
            chk($sformatf("row%0d empty", i), c_empty, tbl[i].cap == 8'h00);
            chk($sformatf("row%0d gate_cycles", i), c_gate, tbl[i].gate);
            chk($sformatf("row%0d pulse_width", i), c_extra, 1'b0);
        end

        // Two invalid exits leave the round-robin pointer favouring entry
        run_txn(1'b0, 1'b1, 8'h00);
        chk("pre-conflict err a", c_err, 1'b1);
        run_txn(1'b0, 1'b1, 8'h00);
        chk("pre-conflict err b", c_err, 1'b1);

        // Simultaneous requests against a full lot
        @(negedge clk);
        entry_req = 1'b1; exit_req = 1'b1; exit_slot = 8'h80;
        @(posedge clk); #1;
        got = 1'b0; wcyc = 0;
`ifdef PARKING_RR_ARB_EN
        chk("conflict first reject", entry_reject, 1'b1);
        chk("conflict first no exit_ack", exit_ack, 1'b0);
        chk("conflict first capacity", capacity, 8'hFF);
        chk("conflict reject gate", gate_open, 1'b0);
        @(negedge clk);
        entry_req = 1'b0;
        for (int n = 1; n <= 20; n++) begin
            @(posedge clk); #1;
            if (exit_ack) begin got = 1'b1; wcyc = n; break; end
        end
        chk("conflict second exit_ack seen", got, 1'b1);
        chk("conflict second latency", wcyc, 2);
        chk("conflict second capacity", capacity, 8'h7F);
        chk("conflict second count", occupied_count, 4'd7);
        chk("conflict second full", full, 1'b0);
        @(negedge clk);
        exit_req = 1'b0;
`else
        chk("conflict first exit_ack", exit_ack, 1'b1);
        chk("conflict first no entry_ack", entry_ack, 1'b0);
        chk("conflict first capacity", capacity, 8'h7F);
        chk("conflict first count", occupied_count, 4'd7);
        chk("conflict first full", full, 1'b0);
        @(negedge clk);
        exit_req = 1'b0;
        for (int n = 1; n <= 20; n++) begin
            @(posedge clk); #1;
            if (entry_ack) begin got = 1'b1; wcyc = n; break; end
        end
        chk("conflict second entry_ack seen", got, 1'b1);
        chk("conflict second latency", wcyc, GC + 2);
        chk("conflict second entry_slot", entry_slot, 8'h80);
        chk("conflict second capacity", capacity, 8'hFF);
        chk("conflict second count", occupied_count, 4'd8);
        chk("conflict second full", full, 1'b1);
        @(negedge clk);
        entry_req = 1'b0;
`endif
        repeat (GC + 3) @(posedge clk);

        // Reset while the gate is open; entry_req held across reset
        @(negedge clk);
        exit_req = 1'b1; exit_slot = 8'h01;
        @(posedge clk); #1;
        chk("pre-reset exit_ack", exit_ack, 1'b1);
        @(negedge clk);
        exit_req = 1'b0;
        @(posedge clk); #1;
        chk("pre-reset gate_open", gate_open, 1'b1);
        @(negedge clk);
        entry_req = 1'b1;
        rst_n = 1'b0;
        #1;
        chk_reset_vals("midgate reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("post-reset entry_ack", entry_ack, 1'b1);
        chk("post-reset entry_slot", entry_slot, 8'h01);
        chk("post-reset capacity", capacity, 8'h01);
        chk("post-reset gate_open", gate_open, 1'b1);
        @(negedge clk);
        entry_req = 1'b0;
        repeat (GC + 2) @(posedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
